// File: rtl/packet_matrix_scheduler.sv
// Packet-granular output scheduler: least-recently-served matrix arbitration
// with the grant held on one requester from its first flit until its tail
// flit handshakes. The datapath is a pure combinational mux; there is no flit storage.

// One arbitration lane: this requester wins if it is requesting and beats
// every other active requester (the diagonal of its row is tied high).
module psched_lane #(
    parameter int NUM = 4
) (
    input  logic           req,
    input  logic [NUM-1:0] valid,
    input  logic [NUM-1:0] beats,
    output logic           win
);
    assign win = req & (&(beats | ~valid));
endmodule

module packet_matrix_scheduler #(
    parameter int NUM    = 4,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM-1:0]        i_valid,
    input  logic [NUM-1:0]        i_last,
    input  logic [NUM*DATA_W-1:0] i_data,
    output logic [NUM-1:0]        o_ready,
    output logic                  o_valid,
    output logic                  o_last,
    output logic [DATA_W-1:0]     o_data,
    input  logic                  i_ready,
    output logic [NUM-1:0]        o_owner,
    output logic                  o_busy
);
    localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                       state, state_nxt;
    logic [IW-1:0]                owner, owner_nxt, win_idx, upd_idx;
    logic                         upd_en, any_win, hs, cmp;
    logic [NUM-1:0][NUM-1:0]      upper;   // stored bits, only i<j populated
    logic [NUM-1:0][NUM-1:0]      prio;    // full view: prio[i][j]=1 -> i beats j
    logic [NUM-1:0][NUM-1:0]      valid_rep;
    logic [NUM-1:0]               win, own_oh;
    logic [NUM-1:0][DATA_W-1:0]   data_v;

    assign data_v = i_data;
    assign own_oh = NUM'(1) << owner;

    // Upper triangle flops; the lower triangle is implied by antisymmetry.
    for (genvar gi = 0; gi < NUM; gi++) begin : g_row
        for (genvar gj = 0; gj < NUM; gj++) begin : g_col
            if (gi < gj) begin : g_up
                logic q;
                // Winner drops below everyone: clear its row bit, set its column bit.
                always_ff @(posedge clk) begin
                    if (!rst)                                   q <= 1'b1;
                    else if (upd_en && upd_idx == IW'(gi))      q <= 1'b0;
                    else if (upd_en && upd_idx == IW'(gj))      q <= 1'b1;
                end
                assign upper[gi][gj] = q;
                assign prio[gi][gj]  = q;
            end else begin : g_nostore
                assign upper[gi][gj] = 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < NUM; gi++) begin : g_view
        for (genvar gj = 0; gj < NUM; gj++) begin : g_col
            if (gi > gj) begin : g_lo
                assign prio[gi][gj] = ~upper[gj][gi];
            end else if (gi == gj) begin : g_diag
                assign prio[gi][gj] = 1'b1;
            end
        end
        assign valid_rep[gi] = i_valid;
    end

    psched_lane #(.NUM(NUM)) u_lane [NUM-1:0] (
        .req   (i_valid),
        .valid (valid_rep),
        .beats (prio),
        .win   (win)
    );

    // Encode the (one-hot) winner.
    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM; k++)
            if (win[k]) win_idx = IW'(k);
    end

    assign any_win = |win;

    // Output mux: locked owner, or this cycle's arbitration winner.
    always_comb begin
        o_owner = '0;
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_data  = '0;
        o_ready = '0;
        if (state == LOCKED) begin
            o_owner = own_oh;
            o_valid = i_valid[owner];
            o_last  = i_valid[owner] & i_last[owner];
            o_data  = data_v[owner];
            o_ready = own_oh & {NUM{i_ready}};
        end else if (any_win) begin
            o_owner = win;
            o_valid = 1'b1;
            o_last  = i_last[win_idx];
            o_data  = data_v[win_idx];
            o_ready = win & {NUM{i_ready}};
        end
    end

    assign hs     = o_valid & i_ready;
    assign cmp    = hs & o_last;
    assign o_busy = (state == LOCKED);

    // Next state: lock on any offered flit that does not complete a packet.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        upd_en    = 1'b0;
        upd_idx   = (state == LOCKED) ? owner : win_idx;
        case (state)
            IDLE: begin
                if (any_win) begin
                    if (cmp) begin
                        upd_en = 1'b1;
                    end else begin
                        state_nxt = LOCKED;
                        owner_nxt = win_idx;
                    end
                end
            end
            LOCKED: begin
                if (cmp) begin
                    state_nxt = IDLE;
                    upd_en    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end
endmodule

// File: doc/packet_matrix_scheduler.md
Name: packet_matrix_scheduler

Overview:
Shares one NoC output link between NUM input ports at packet granularity. Requesters are ordered by least-recently-served matrix priority, the same policy as matrix_arbiter. Once a requester's first flit is presented, the output stays locked to it until its tail flit (i_last) handshakes. The datapath is a combinational mux; no flit storage. The block sits between the input-port buffers and the output link register of a router port.

Parameters:
NUM, 4, number of requesting input ports (≥2)
DATA_W, 32, flit payload width in bits

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-low (asserted when 0)
i_valid  input  NUM  per-requester flit valid
i_last  input  NUM  per-requester tail-flit marker, qualified by i_valid
i_data  input  NUM*DATA_W  per-requester flit; requester k occupies bits [k*DATA_W +: DATA_W]
o_ready  output  NUM  per-requester accept; one-hot or zero
o_valid  output  1  flit valid toward output link
o_last  output  1  tail marker toward output link
o_data  output  DATA_W  selected flit
i_ready  input  1  output link accept
o_owner  output  NUM  one-hot current selection; zero when nothing is selected
o_busy  output  1  1 while in LOCKED

Behaviour:
- Registered state:
  - fsm ∈ {IDLE, LOCKED}
  - owner index, log2(NUM) bits
  - priority matrix, NUM×NUM bits; only the upper triangle needs storage. prio[i][j]=1 means i beats j.
- Reset (rst=0 at a rising edge):
  - fsm=IDLE, owner=0.
  - prio[i][j]=1 for all i<j, so index 0 has highest priority.
  - Reset mid-packet abandons the packet with no completion and no matrix update.
- Combinational outputs while rst=0 follow the normal rules below; state is only held in reset.
- Winner W in IDLE: the unique k with i_valid[k]=1 and, for every other j with i_valid[j]=1, prio[k][j]=1. If no i_valid is set, there is no winner.
- IDLE outputs:
  - With winner: o_owner=onehot(W), o_valid=1, o_last=i_last[W], o_data=i_data[W], o_ready=onehot(W)&{NUM{i_ready}}.
  - With no winner: o_owner=0, o_valid=0, o_last=0, o_data=0, o_ready=0.
- LOCKED outputs (owner O):
  - o_owner=onehot(O), o_valid=i_valid[O], o_last=i_valid[O]&i_last[O], o_data=i_data[O].
  - o_ready=onehot(O)&{NUM{i_ready}}, even when i_valid[O]=0, so the owner may present on any later cycle.
  - All other requesters see o_ready=0 regardless of their i_valid.
- Handshake: hs = o_valid & i_ready. Completion: cmp = hs & o_last.
- Transitions:
  - IDLE, winner W, cmp=1 (single-flit packet): stay IDLE; matrix update for W.
  - IDLE, winner W, cmp=0 (stalled, or a non-tail flit accepted): go LOCKED with owner=W. This keeps the offered flit stable under backpressure.
  - IDLE, no winner: stay IDLE.
  - LOCKED, cmp=1: go IDLE; matrix update for owner. The next cycle re-arbitrates with the new priorities.
  - LOCKED, otherwise: stay LOCKED, including bubbles where i_valid[O]=0.
- Matrix update for winner X, next cycle:
  - prio[X][j]=0 and prio[j][X]=1 for all j≠X, so X becomes lowest priority.
  - All other entries are unchanged.
  - The matrix stays antisymmetric and transitive; exactly one winner exists whenever any request is present.
- Latency: zero-cycle combinational path from input to output. Arbitration decision and lock take effect in the same cycle the first flit is offered.
- Throughput: one flit per cycle when i_ready=1. Back-to-back packets from different owners have no idle cycle: the IDLE cycle after completion is itself an arbitration and transfer cycle.
- Requester obligations: hold i_valid, i_last and i_data stable until handshake. i_last with i_valid=0 is ignored.
- o_busy = (fsm==LOCKED).

Test Plan:
- Round-robin, all single-flit: rst for 2 cycles. i_valid=4'b1111, i_last=4'b1111, i_ready=1. Require o_owner sequence 0001, 0010, 0100, 1000, repeated for 10 rounds, o_valid=1 every cycle, o_busy=0 throughout.
- Packet lock: requester 0 sends 3 flits (tail on third); requester 1 holds a 1-flit packet from the same cycle. Require owner 0 for 3 cycles with o_busy=1 on cycles 2–3, o_ready[1]=0 during them, then owner 1 on cycle 4. Then assert all four requesters, all single-flit; require order 2, 3, 0, 1.
- Backpressure hold: i_ready=0, only requester 2 valid (single-flit). Next cycle requester 0 also raises valid. Require o_owner=0100, o_busy=1, o_data=i_data[2] held while stalled. After i_ready=1, requester 2 completes, then requester 0 is granted.
- Bubble in packet: owner 3 drops i_valid for 2 cycles mid-packet while requester 1 is valid. Require o_valid=0, o_owner=1000, o_ready=4'b1000 (i_ready=1). Requester 1 is not served until requester 3's tail handshakes.
- Reset mid-packet: requester 1 is LOCKED after flit 1 of 4; assert rst=0 for 1 cycle. Require o_busy=0, priority back to index 0 highest. With all four valid and single-flit after reset, order is 0, 1, 2, 3.
- Idle: no requests. Require o_valid=0, o_ready=0, o_owner=0, o_busy=0, and the matrix unchanged, checked by the next grant order.
